col_elastic_array: RTL and testbench

- Parametrised successor to the per-column valid/data pipeline used in the column-array tops.
- COLS independent column lanes, each with a DEPTH-entry elastic FIFO and a valid/ready handshake on both sides.
- Optional lockstep mode releases one word from every enabled column in the same cycle, so downstream column logic stays aligned.
- Sits between the column producers and the per-column consumer stages inside a generate-per-column top.

---
 rtl/col_elastic_array.sv | 124 ++++++++++++
 tb/tb_col_elastic_array.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/col_elastic_array.sv
// Column lane array: each lane owns a DEPTH-entry elastic FIFO with valid/ready on both sides.
// An optional lockstep mode pops every enabled lane together so downstream lanes stay aligned.
module col_elastic_array #(
    parameter int COLS   = 4,
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         lockstep,
    input  logic [COLS-1:0]              col_en,
    input  logic [COLS-1:0]              ival,
    input  logic [COLS-1:0][DATA_W-1:0]  idata,
    output logic [COLS-1:0]              iready,
    output logic [COLS-1:0]              oval,
    output logic [COLS-1:0][DATA_W-1:0]  odata,
    input  logic [COLS-1:0]              oready,
    output logic [COLS-1:0][LVL_W-1:0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0]            mem_r [COLS][DEPTH];
    logic [COLS-1:0][PTR_W-1:0]   wr_ptr_r;
    logic [COLS-1:0][PTR_W-1:0]   rd_ptr_r;
    logic [COLS-1:0][LVL_W-1:0]   level_r;
    logic [COLS-1:0]              full_s;
    logic [COLS-1:0]              empty_s;
    logic [COLS-1:0]              push_s;
    logic [COLS-1:0]              pop_s;
    logic                         any_en_s;
    logic                         all_nonempty_s;
    logic                         all_ready_s;
    logic                         grp_avail_s;
    logic                         grp_pop_s;

    // Full/empty flags from registered occupancy
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            full_s[c]  = (level_r[c] == FULL_LVL);
            empty_s[c] = (level_r[c] == {LVL_W{1'b0}});
        end
    end

    // Lockstep group status; disabled lanes are transparent to both ANDs
    always_comb begin
        any_en_s       = 1'b0;
        all_nonempty_s = 1'b1;
        all_ready_s    = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            any_en_s       = any_en_s | col_en[c];
            all_nonempty_s = all_nonempty_s & (~col_en[c] | ~empty_s[c]);
            all_ready_s    = all_ready_s & (~col_en[c] | oready[c]);
        end
        grp_avail_s = any_en_s & all_nonempty_s & ~rst;
        grp_pop_s   = grp_avail_s & all_ready_s;
    end

    // Handshake decode; iready/oval never look at ival or oready
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            iready[c] = col_en[c] & ~full_s[c] & ~rst;
            if (lockstep) begin
                oval[c]  = col_en[c] & grp_avail_s;
                pop_s[c] = col_en[c] & grp_pop_s;
            end else begin
                oval[c]  = col_en[c] & ~empty_s[c] & ~rst;
                pop_s[c] = col_en[c] & ~empty_s[c] & ~rst & oready[c];
            end
            push_s[c] = ival[c] & col_en[c] & ~full_s[c] & ~rst;
        end
    end

    // Pointer and occupancy update, with reset and per-lane flush
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                if (!col_en[c]) begin
                    wr_ptr_r[c] <= {PTR_W{1'b0}};
                    rd_ptr_r[c] <= {PTR_W{1'b0}};
                    level_r[c]  <= {LVL_W{1'b0}};
                end else begin
                    if (push_s[c]) begin
                        wr_ptr_r[c] <= wr_ptr_r[c] + PTR_ONE;
                    end
                    if (pop_s[c]) begin
                        rd_ptr_r[c] <= rd_ptr_r[c] + PTR_ONE;
                    end
                    case ({push_s[c], pop_s[c]})
                        2'b10:   level_r[c] <= level_r[c] + LVL_ONE;
                        2'b01:   level_r[c] <= level_r[c] - LVL_ONE;
                        default: level_r[c] <= level_r[c];
                    endcase
                end
            end
        end
    end

    // Payload storage; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        for (int c = 0; c < COLS; c++) begin
            if (push_s[c]) begin
                mem_r[c][wr_ptr_r[c]] <= idata[c];
            end
        end
    end

    // Head-of-FIFO read from registered storage and pointer
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            odata[c] = mem_r[c][rd_ptr_r[c]];
        end
    end

    assign level = level_r;

endmodule

// File: tb/tb_col_elastic_array.sv
// Scoreboard bench for col_elastic_array: per-lane expected-data queues fed by accepted pushes,
// popped and compared by a monitor whenever a lane hands a word downstream.
module tb_col_elastic_array;
    localparam int COLS   = 4;
    localparam int DATA_W = 2;
    localparam int DEPTH  = 4;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        lockstep;
    logic [COLS-1:0]             col_en;
    logic [COLS-1:0]             ival;
    logic [COLS-1:0][DATA_W-1:0] idata;
    logic [COLS-1:0]             iready;
    logic [COLS-1:0]             oval;
    logic [COLS-1:0][DATA_W-1:0] odata;
    logic [COLS-1:0]             oready;
    logic [COLS-1:0][LVL_W-1:0]  level;

    int checks   = 0;
    int failures = 0;
    int npops    = 0;
    int max_lvl1 = 0;
    bit mon_en   = 1'b0;

    logic [DATA_W-1:0] exp_q [COLS][$];
    logic [COLS-1:0]   exp_iready;
    logic [COLS-1:0]   exp_oval;
    logic [COLS-1:0]   last_acc;

    always #5 clk = ~clk;

    col_elastic_array #(.COLS(COLS), .DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk(clk), .rst(rst), .lockstep(lockstep), .col_en(col_en),
        .ival(ival), .idata(idata), .iready(iready),
        .oval(oval), .odata(odata), .oready(oready), .level(level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: derive expected handshake from queue occupancy, compare, and pop on transfers
    always @(negedge clk) begin
        bit any_en, all_ne, all_rdy, gpop;
        if (mon_en) begin
            any_en = 1'b0; all_ne = 1'b1; all_rdy = 1'b1;
            for (int c = 0; c < COLS; c++) begin
                if (col_en[c]) begin
                    any_en = 1'b1;
                    if (exp_q[c].size() == 0) all_ne = 1'b0;
                    if (!oready[c]) all_rdy = 1'b0;
                end
            end
            gpop = !rst && any_en && all_ne && all_rdy;
            for (int c = 0; c < COLS; c++) begin
                exp_iready[c] = !rst && col_en[c] && (exp_q[c].size() < DEPTH);
                exp_oval[c]   = !rst && col_en[c] &&
                                (lockstep ? (any_en && all_ne) : (exp_q[c].size() > 0));
            end
            chk("iready", 32'(iready), 32'(exp_iready));
            chk("oval", 32'(oval), 32'(exp_oval));
            for (int c = 0; c < COLS; c++) begin
                chk($sformatf("level%0d", c), 32'(level[c]), 32'(exp_q[c].size()));
            end
            if (32'(level[1]) > 32'(max_lvl1)) max_lvl1 = int'(level[1]);
            for (int c = 0; c < COLS; c++) begin
                if (exp_oval[c] && (lockstep ? gpop : oready[c])) begin
                    chk($sformatf("odata%0d", c), 32'(odata[c]), 32'(exp_q[c].pop_front()));
                    npops++;
                end
            end
        end
    end

    // One cycle of stimulus; after the monitor runs, record accepted pushes and flushes
    task automatic step(input logic ls, input logic [3:0] en, input logic [3:0] iv,
                        input logic [7:0] id, input logic [3:0] ordy);
        lockstep = ls; col_en = en; ival = iv; idata = id; oready = ordy;
        @(negedge clk);
        #1;
        for (int c = 0; c < COLS; c++) begin
            last_acc[c] = ival[c] && exp_iready[c];
            if (last_acc[c]) exp_q[c].push_back(idata[c]);
        end
        for (int c = 0; c < COLS; c++) begin
            if (rst || !col_en[c]) exp_q[c].delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] en_r, iv_r, ord_r;
        logic [7:0] id_r;
        logic       ls_r;
        rst = 1'b1; lockstep = 1'b0; col_en = 4'h0; ival = 4'h0; idata = 8'h00; oready = 4'h0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(1'b0, 4'hF, 4'hF, 8'hFF, 4'hF);   // reset held: nothing accepted
        rst = 1'b0;

        // Three words through column 0 with the consumer always ready
        step(1'b0, 4'hF, 4'b0001, 8'h01, 4'hF);
        step(1'b0, 4'hF, 4'b0001, 8'h02, 4'hF);
        step(1'b0, 4'hF, 4'b0001, 8'h03, 4'hF);
        step(1'b0, 4'hF, 4'b0000, 8'h00, 4'hF);
        step(1'b0, 4'hF, 4'b0000, 8'h00, 4'hF);

        // Fill column 2, then offer a push while full and popping
        for (int k = 0; k < 4; k++) step(1'b0, 4'hF, 4'b0100, 8'(k << 4), 4'h0);
        step(1'b0, 4'hF, 4'b0100, 8'h10, 4'b0100);
        step(1'b0, 4'hF, 4'b0100, 8'h10, 4'b0100);
        for (int k = 0; k < 4; k++) step(1'b0, 4'hF, 4'b0000, 8'h00, 4'hF);

        // Lockstep group with column 2 disabled
        step(1'b1, 4'b1011, 4'b0011, 8'b00_00_10_01, 4'h0);
        step(1'b1, 4'b1011, 4'b1000, 8'b11_00_00_00, 4'h0);
        step(1'b1, 4'b1011, 4'b0000, 8'h00, 4'b0011);
        step(1'b1, 4'b1011, 4'b0000, 8'h00, 4'b1011);
        step(1'b1, 4'b1011, 4'b0000, 8'h00, 4'b0000);

        // Wrap-around on column 1
        max_lvl1 = 0;
        for (int k = 0; k < 10; k++) step(1'b0, 4'hF, 4'b0010, 8'($urandom_range(0, 3) << 2), 4'b0010);
        step(1'b0, 4'hF, 4'b0000, 8'h00, 4'b0010);
        chk("wrap_max_level1", 32'(max_lvl1), 32'd1);

        // Flush column 3 while holding three words
        for (int k = 0; k < 3; k++) step(1'b0, 4'hF, 4'b1000, 8'(k << 6), 4'h0);
        step(1'b0, 4'b0111, 4'b0000, 8'h00, 4'hF);
        step(1'b0, 4'hF, 4'b0000, 8'h00, 4'hF);
        step(1'b0, 4'hF, 4'b1000, 8'hC0, 4'hF);
        step(1'b0, 4'hF, 4'b0000, 8'h00, 4'hF);

        // Reset with every lane half-full and producers pushing
        for (int k = 0; k < 2; k++) step(1'b0, 4'hF, 4'hF, 8'($urandom), 4'h0);
        rst = 1'b1;
        step(1'b0, 4'hF, 4'hF, 8'hA5, 4'h0);
        rst = 1'b0;
        step(1'b0, 4'hF, 4'h0, 8'h00, 4'hF);
        chk("post_rst_level", 32'(level), 32'd0);

        // Randomised traffic with producer hold, mode and enable changes, rare resets
        ls_r = 1'b0; en_r = 4'hF; iv_r = 4'h0; id_r = 8'h00; last_acc = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) ls_r = ~ls_r;
            if ($urandom_range(0, 29) == 0) en_r[$urandom_range(0, 3)] ^= 1'b1;
            for (int c = 0; c < COLS; c++) begin
                if (!(iv_r[c] && !last_acc[c] && en_r[c] && !rst)) begin
                    iv_r[c] = ($urandom_range(0, 2) != 0);
                    id_r[c*2 +: 2] = 2'($urandom);
                end
            end
            ord_r = 4'($urandom) | 4'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            step(ls_r, en_r, iv_r, id_r, ord_r);
        end
        rst = 1'b0;
        chk("pops_seen", 32'(npops > 500), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
